// File: rtl/operand_bus_agent_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : operand_bus_agent_pkg
//  Purpose  : Shared state codes, command-word field layout, flag encodings
//             and internal encodings for the operand bus agent.
//  Revision : 1.0  initial release
// ============================================================================
package operand_bus_agent_pkg;

    // Sequencer state codes (shared with the instruction state sequencer)
    localparam logic [7:0] c_WAIT_FOR_START = 8'h00;
    localparam logic [7:0] c_READ_COND      = 8'h01;
    localparam logic [7:0] c_READ_SRC1      = 8'h02;
    localparam logic [7:0] c_READ_SRC0      = 8'h03;
    localparam logic [7:0] c_READ_COND_P    = 8'h04;
    localparam logic [7:0] c_READ_SRC1_P    = 8'h05;
    localparam logic [7:0] c_READ_SRC0_P    = 8'h06;
    localparam logic [7:0] c_ALU_BEGIN      = 8'h07;
    localparam logic [7:0] c_WRITE_DST      = 8'h08;
    localparam logic [7:0] c_WRITE_COND     = 8'h09;
    localparam logic [7:0] c_WRITE_SRC1     = 8'h0A;
    localparam logic [7:0] c_WRITE_SRC0     = 8'h0B;

    // Command word register-index fields (4 bits each)
    localparam int c_SRC1_LSB = 0;
    localparam int c_SRC0_LSB = 4;
    localparam int c_DST_LSB  = 8;
    localparam int c_COND_LSB = 12;
    // Pointer bits and flag pairs, ordered S1/S0/D/Cond from the LSB
    localparam int c_PTR_LSB  = 16;
    localparam int c_FLAG_LSB = 20;
    localparam int c_PAIR_SRC1 = 0;
    localparam int c_PAIR_SRC0 = 1;
    localparam int c_PAIR_DST  = 2;
    localparam int c_PAIR_COND = 3;

    // Flag pair encodings
    localparam logic [1:0] c_FLAG_NONE = 2'b11;
    localparam logic [1:0] c_FLAG_INC  = 2'b01;
    localparam logic [1:0] c_FLAG_DEC  = 2'b10;

    // Work class of the current sequencer state
    localparam int c_KIND_W = 3;
    localparam logic [c_KIND_W-1:0] c_K_NOP   = 3'd0;
    localparam logic [c_KIND_W-1:0] c_K_WAIT  = 3'd1;
    localparam logic [c_KIND_W-1:0] c_K_READ  = 3'd2;
    localparam logic [c_KIND_W-1:0] c_K_READP = 3'd3;
    localparam logic [c_KIND_W-1:0] c_K_ALU   = 3'd4;
    localparam logic [c_KIND_W-1:0] c_K_WDST  = 3'd5;
    localparam logic [c_KIND_W-1:0] c_K_WBACK = 3'd6;

    // Operand selector
    localparam logic [1:0] c_OP_NONE = 2'd0;
    localparam logic [1:0] c_OP_COND = 2'd1;
    localparam logic [1:0] c_OP_SRC1 = 2'd2;
    localparam logic [1:0] c_OP_SRC0 = 2'd3;

    // Agent FSM encoding
    localparam int c_FSM_W = 3;
    localparam logic [c_FSM_W-1:0] c_S_IDLE   = 3'd0;
    localparam logic [c_FSM_W-1:0] c_S_BUS    = 3'd1;
    localparam logic [c_FSM_W-1:0] c_S_PTR2   = 3'd2;
    localparam logic [c_FSM_W-1:0] c_S_ALU    = 3'd3;
    localparam logic [c_FSM_W-1:0] c_S_DONE   = 3'd4;
    localparam logic [c_FSM_W-1:0] c_S_SETTLE = 3'd5;

    function automatic logic [3:0] regOf(input logic [31:0] cmd, input int lsb);
        return cmd[lsb +: 4];
    endfunction

    function automatic logic [1:0] flagsOf(input logic [31:0] cmd, input int pair);
        return cmd[c_FLAG_LSB + 2*pair +: 2];
    endfunction

    function automatic logic ptrOf(input logic [31:0] cmd, input int pair);
        return cmd[c_PTR_LSB + pair];
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_bus_agent_cmd_field_decode.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_field_decode
//  Purpose  : Combinational decode of the sequencer state and instruction
//             word into a work class, operand select, register index, flag
//             pair and destination pointer bit.
//  Ports    : i_state   - current sequencer state
//             i_command - instruction word
//             o_kind    - work class (c_K_*)
//             o_opSel   - operand touched by this state (c_OP_*)
//             o_regIdx  - register index for the state's operand/dst
//             o_flags   - flag pair for the state's operand/dst
//             o_dstPtr  - destination pointer bit
//  Revision : 1.0  initial release
// ============================================================================
module cmd_field_decode
    import operand_bus_agent_pkg::*;
#(
    parameter int STATE_W = 8
) (
    input  logic [STATE_W-1:0]  i_state,
    input  logic [31:0]         i_command,
    output logic [c_KIND_W-1:0] o_kind,
    output logic [1:0]          o_opSel,
    output logic [3:0]          o_regIdx,
    output logic [1:0]          o_flags,
    output logic                o_dstPtr
);

    // Reserved bits and the operand pointer bits are consumed by the sequencer only
    logic w_unusedCmd;
    assign w_unusedCmd = ^{i_command[31:28], i_command[19], i_command[17:16]};

    assign o_dstPtr = ptrOf(i_command, c_PAIR_DST);

    always_comb begin
        o_kind   = c_K_NOP;
        o_opSel  = c_OP_NONE;
        o_regIdx = 4'd0;
        o_flags  = c_FLAG_NONE;
        case (i_state)
            STATE_W'(c_WAIT_FOR_START): o_kind = c_K_WAIT;
            STATE_W'(c_READ_COND): begin
                o_kind   = c_K_READ;
                o_opSel  = c_OP_COND;
                o_regIdx = regOf(i_command, c_COND_LSB);
                o_flags  = flagsOf(i_command, c_PAIR_COND);
            end
            STATE_W'(c_READ_SRC1): begin
                o_kind   = c_K_READ;
                o_opSel  = c_OP_SRC1;
                o_regIdx = regOf(i_command, c_SRC1_LSB);
                o_flags  = flagsOf(i_command, c_PAIR_SRC1);
            end
            STATE_W'(c_READ_SRC0): begin
                o_kind   = c_K_READ;
                o_opSel  = c_OP_SRC0;
                o_regIdx = regOf(i_command, c_SRC0_LSB);
                o_flags  = flagsOf(i_command, c_PAIR_SRC0);
            end
            STATE_W'(c_READ_COND_P): begin
                o_kind  = c_K_READP;
                o_opSel = c_OP_COND;
            end
            STATE_W'(c_READ_SRC1_P): begin
                o_kind  = c_K_READP;
                o_opSel = c_OP_SRC1;
            end
            STATE_W'(c_READ_SRC0_P): begin
                o_kind  = c_K_READP;
                o_opSel = c_OP_SRC0;
            end
            STATE_W'(c_ALU_BEGIN): o_kind = c_K_ALU;
            STATE_W'(c_WRITE_DST): begin
                o_kind   = c_K_WDST;
                o_regIdx = regOf(i_command, c_DST_LSB);
                o_flags  = flagsOf(i_command, c_PAIR_DST);
            end
            STATE_W'(c_WRITE_COND): begin
                o_kind   = c_K_WBACK;
                o_opSel  = c_OP_COND;
                o_regIdx = regOf(i_command, c_COND_LSB);
                o_flags  = flagsOf(i_command, c_PAIR_COND);
            end
            STATE_W'(c_WRITE_SRC1): begin
                o_kind   = c_K_WBACK;
                o_opSel  = c_OP_SRC1;
                o_regIdx = regOf(i_command, c_SRC1_LSB);
                o_flags  = flagsOf(i_command, c_PAIR_SRC1);
            end
            STATE_W'(c_WRITE_SRC0): begin
                o_kind   = c_K_WBACK;
                o_opSel  = c_OP_SRC0;
                o_regIdx = regOf(i_command, c_SRC0_LSB);
                o_flags  = flagsOf(i_command, c_PAIR_SRC0);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/operand_bus_agent.sv
`default_nettype none
// ============================================================================
//  Module   : operand_bus_agent
//  Purpose  : Executes the per-state work requested by the instruction state
//             sequencer (register reads, pointer dereferences, ALU kick-off,
//             result write, post-inc/dec write-back) on the shared bus and
//             returns a one-cycle next_state completion strobe.
//  Ports    : clk, rst            - posedge clock, sync active-high reset
//             start               - release from WAIT_FOR_START
//             state, command      - sequencer state and instruction word
//             alu_result/alu_done - ALU output and completion
//             alu_start           - one-cycle ALU launch
//             bus_addr/bus_wdata  - bus address and write data
//             bus_rd/bus_wr       - level requests, held until bus_ack
//             bus_rdata/bus_ack   - bus read data and acknowledge
//             cond/src1/src0      - latched operands
//             next_state          - completion strobe to the sequencer
//  Revision : 1.0  initial release
// ============================================================================
module operand_bus_agent
    import operand_bus_agent_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                STATE_W  = 8,
    parameter logic [DATA_W-1:0] REG_BASE = DATA_W'(32'hFFFF_FF00)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] state,
    input  logic [31:0]        command,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_done,
    output logic               alu_start,
    output logic [DATA_W-1:0]  bus_addr,
    output logic [DATA_W-1:0]  bus_wdata,
    output logic               bus_rd,
    output logic               bus_wr,
    input  logic [DATA_W-1:0]  bus_rdata,
    input  logic               bus_ack,
    output logic [DATA_W-1:0]  cond,
    output logic [DATA_W-1:0]  src1,
    output logic [DATA_W-1:0]  src0,
    output logic               next_state
);

    logic [c_KIND_W-1:0] w_kind;
    logic [1:0]          w_opSel;
    logic [3:0]          w_regIdx;
    logic [1:0]          w_flags;
    logic                w_dstPtr;
    logic [DATA_W-1:0]   w_opVal;
    logic [DATA_W-1:0]   w_regAddr;

    logic [c_FSM_W-1:0]  r_fsm;
    logic [1:0]          r_tgt;     // operand to load when the read is acked
    logic                r_ptrWr;   // current read fetches the dst pointer

    cmd_field_decode #(
        .STATE_W (STATE_W)
    ) u_decode (
        .i_state   (state),
        .i_command (command),
        .o_kind    (w_kind),
        .o_opSel   (w_opSel),
        .o_regIdx  (w_regIdx),
        .o_flags   (w_flags),
        .o_dstPtr  (w_dstPtr)
    );

    always_comb begin
        case (w_opSel)
            c_OP_COND: w_opVal = cond;
            c_OP_SRC1: w_opVal = src1;
            c_OP_SRC0: w_opVal = src0;
            default:   w_opVal = '0;
        endcase
    end

    assign w_regAddr = REG_BASE + DATA_W'(w_regIdx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm      <= c_S_IDLE;
            r_tgt      <= c_OP_NONE;
            r_ptrWr    <= 1'b0;
            alu_start  <= 1'b0;
            next_state <= 1'b0;
            bus_rd     <= 1'b0;
            bus_wr     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            cond       <= '0;
            src1       <= '0;
            src0       <= '0;
        end else begin
            alu_start  <= 1'b0;
            next_state <= 1'b0;
            case (r_fsm)
                c_S_IDLE: begin
                    case (w_kind)
                        c_K_WAIT: begin
                            if (start) begin
                                next_state <= 1'b1;
                                r_fsm      <= c_S_DONE;
                            end
                        end
                        c_K_READ: begin
                            if (w_flags == c_FLAG_NONE) begin
                                next_state <= 1'b1;
                                r_fsm      <= c_S_DONE;
                            end else begin
                                bus_addr <= w_regAddr;
                                bus_rd   <= 1'b1;
                                r_tgt    <= w_opSel;
                                r_ptrWr  <= 1'b0;
                                r_fsm    <= c_S_BUS;
                            end
                        end
                        c_K_READP: begin
                            bus_addr <= w_opVal;
                            bus_rd   <= 1'b1;
                            r_tgt    <= w_opSel;
                            r_ptrWr  <= 1'b0;
                            r_fsm    <= c_S_BUS;
                        end
                        c_K_ALU: begin
                            alu_start <= 1'b1;
                            r_fsm     <= c_S_ALU;
                        end
                        c_K_WDST: begin
                            if (w_flags == c_FLAG_NONE) begin
                                next_state <= 1'b1;
                                r_fsm      <= c_S_DONE;
                            end else begin
                                bus_addr <= w_regAddr;
                                r_tgt    <= c_OP_NONE;
                                r_ptrWr  <= w_dstPtr;
                                r_fsm    <= c_S_BUS;
                                if (w_dstPtr) begin
                                    bus_rd <= 1'b1;
                                end else begin
                                    bus_wdata <= alu_result;
                                    bus_wr    <= 1'b1;
                                end
                            end
                        end
                        c_K_WBACK: begin
                            if (w_flags == c_FLAG_INC || w_flags == c_FLAG_DEC) begin
                                bus_addr  <= w_regAddr;
                                bus_wdata <= (w_flags == c_FLAG_INC) ? w_opVal + DATA_W'(1)
                                                                     : w_opVal - DATA_W'(1);
                                bus_wr    <= 1'b1;
                                r_tgt     <= c_OP_NONE;
                                r_ptrWr   <= 1'b0;
                                r_fsm     <= c_S_BUS;
                            end else begin
                                next_state <= 1'b1;
                                r_fsm      <= c_S_DONE;
                            end
                        end
                        default: begin
                            next_state <= 1'b1;
                            r_fsm      <= c_S_DONE;
                        end
                    endcase
                end
                c_S_BUS: begin
                    if (bus_ack) begin
                        bus_rd <= 1'b0;
                        bus_wr <= 1'b0;
                        if (bus_rd) begin
                            case (r_tgt)
                                c_OP_COND: cond <= bus_rdata;
                                c_OP_SRC1: src1 <= bus_rdata;
                                c_OP_SRC0: src0 <= bus_rdata;
                                default:   ;
                            endcase
                        end
                        if (r_ptrWr) begin
                            // The value just read is the destination address
                            bus_addr  <= bus_rdata;
                            bus_wdata <= alu_result;
                            bus_wr    <= 1'b1;
                            r_ptrWr   <= 1'b0;
                            r_fsm     <= c_S_PTR2;
                        end else begin
                            next_state <= 1'b1;
                            r_fsm      <= c_S_DONE;
                        end
                    end
                end
                c_S_PTR2: begin
                    if (bus_ack) begin
                        bus_wr     <= 1'b0;
                        next_state <= 1'b1;
                        r_fsm      <= c_S_DONE;
                    end
                end
                c_S_ALU: begin
                    if (alu_done) begin
                        next_state <= 1'b1;
                        r_fsm      <= c_S_DONE;
                    end
                end
                // The sequencer moves on during DONE; SETTLE lets its new
                // state propagate so IDLE never re-serves the old one.
                c_S_DONE:   r_fsm <= c_S_SETTLE;
                c_S_SETTLE: r_fsm <= c_S_IDLE;
                default:    r_fsm <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_bus_agent.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_bus_agent
//  Purpose  : Self-checking bench: acts as sequencer, bus slave and ALU,
//             predicting bus traffic, operands and latency per state.
//  Revision : 1.0  initial release
// ============================================================================
module tb_operand_bus_agent;
    import operand_bus_agent_pkg::*;

    localparam logic [31:0] REG_BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst, start, alu_done, alu_start, bus_rd, bus_wr, bus_ack, next_state;
    logic [7:0]  state;
    logic [31:0] command, alu_result, bus_addr, bus_wdata, bus_rdata, cond, src1, src0;

    operand_bus_agent #(.DATA_W(32), .STATE_W(8), .REG_BASE(REG_BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .state(state), .command(command),
        .alu_result(alu_result), .alu_done(alu_done), .alu_start(alu_start),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .cond(cond), .src1(src1), .src0(src0),
        .next_state(next_state)
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } busOp_t;

    logic [31:0] memOv [logic [31:0]];
    logic [31:0] salt;
    logic [31:0] mOp [3];          // model operands: 0 cond, 1 src1, 2 src0
    bit          afterDone = 1'b0; // DUT is in its DONE cycle when the next state is driven
    bit          aluTied   = 1'b0;
    bit          abortRun  = 1'b0;
    int          forceWait = -1;
    logic [31:0] lastRdAddr, lastWrAddr, lastWdata;

    // Per-operand view of the command word and state codes
    int          idxLsb [3] = '{12, 0, 4};
    int          flLsb  [3] = '{26, 20, 22};
    logic [7:0]  rdCode [3] = '{c_READ_COND, c_READ_SRC1, c_READ_SRC0};
    logic [7:0]  rdpCode[3] = '{c_READ_COND_P, c_READ_SRC1_P, c_READ_SRC0_P};
    logic [7:0]  wbCode [3] = '{c_WRITE_COND, c_WRITE_SRC1, c_WRITE_SRC0};

    function automatic logic [31:0] memRd(input logic [31:0] a);
        if (memOv.exists(a)) return memOv[a];
        return (a ^ salt) * 32'h9E37_79B1 + 32'h7F4A_7C15;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle protocol compare process ----------------
    logic        ackAtEdge = 1'b0;
    logic        pReq = 1'b0, pRd = 1'b0, pNs = 1'b0, pAs = 1'b0;
    logic [31:0] pAddr = '0, pWd = '0;

    always @(posedge clk) ackAtEdge <= bus_ack;

    always @(negedge clk) begin
        check("rd_wr_exclusive", 32'(bus_rd & bus_wr), 32'd0);
        if (pReq && (bus_rd || bus_wr) && !ackAtEdge) begin
            check("req_kind_stable", 32'(bus_rd), 32'(pRd));
            check("addr_stable", bus_addr, pAddr);
            if (bus_wr) check("wdata_stable", bus_wdata, pWd);
        end
        check("next_state_single_cycle", 32'(pNs & next_state), 32'd0);
        check("alu_start_single_cycle", 32'(pAs & alu_start), 32'd0);
        pReq  = bus_rd | bus_wr;
        pRd   = bus_rd;
        pAddr = bus_addr;
        pWd   = bus_wdata;
        pNs   = next_state;
        pAs   = alu_start;
    end

    // ---------------- one sequencer state, driven and checked ----------------
    task automatic runState(input logic [7:0] st, input logic [31:0] cmd, input logic [31:0] ar);
        busOp_t      expOps[$];
        busOp_t      e;
        logic [31:0] newOp [3];
        logic [31:0] a;
        logic [1:0]  fl;
        int          cyc, busCyc, w, aluCnt, expLat;
        bit          inReq, gotNs;
        if (abortRun) return;

        // Model: expected bus traffic and resulting operands
        newOp = mOp;
        for (int s = 0; s < 3; s++) begin
            fl = cmd[flLsb[s] +: 2];
            a  = REG_BASE + {28'd0, cmd[idxLsb[s] +: 4]};
            if (st == rdCode[s] && fl != 2'b11) begin
                expOps.push_back('{1'b0, a, 32'd0});
                newOp[s] = memRd(a);
            end
            if (st == rdpCode[s]) begin
                expOps.push_back('{1'b0, mOp[s], 32'd0});
                newOp[s] = memRd(mOp[s]);
            end
            if (st == wbCode[s] && fl == 2'b01) expOps.push_back('{1'b1, a, mOp[s] + 32'd1});
            if (st == wbCode[s] && fl == 2'b10) expOps.push_back('{1'b1, a, mOp[s] - 32'd1});
        end
        if (st == c_WRITE_DST && cmd[25:24] != 2'b11) begin
            a = REG_BASE + {28'd0, cmd[11:8]};
            if (cmd[18]) begin
                expOps.push_back('{1'b0, a, 32'd0});
                expOps.push_back('{1'b1, memRd(a), ar});
            end else begin
                expOps.push_back('{1'b1, a, ar});
            end
        end

        state      = st;
        command    = cmd;
        alu_result = ar;
        start      = (st == c_WAIT_FOR_START);
        cyc = 0; busCyc = 0; w = 0; aluCnt = 0; inReq = 1'b0; gotNs = 1'b0;
        while (!gotNs && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            alu_done  = aluTied ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (alu_start) aluCnt++;
            if (next_state) begin
                gotNs = 1'b1;
            end else if (bus_rd || bus_wr) begin
                if (!inReq) begin
                    inReq  = 1'b1;
                    w      = (forceWait >= 0) ? forceWait : int'($urandom_range(0, 2));
                    busCyc += w + 1;
                end
                if (w == 0) begin
                    check("bus_op_expected", 32'(expOps.size() > 0), 32'd1);
                    if (expOps.size() > 0) begin
                        e = expOps.pop_front();
                        check("bus_is_write", 32'(bus_wr), 32'(e.wr));
                        check("bus_addr", bus_addr, e.addr);
                        if (e.wr) check("bus_wdata", bus_wdata, e.data);
                    end
                    if (bus_rd) begin
                        lastRdAddr = bus_addr;
                        bus_rdata  = memRd(bus_addr);
                    end else begin
                        lastWrAddr = bus_addr;
                        lastWdata  = bus_wdata;
                    end
                    bus_ack = 1'b1;
                    inReq   = 1'b0;
                end else begin
                    w--;
                end
            end
        end

        check("next_state_seen", 32'(gotNs), 32'd1);
        if (!gotNs) abortRun = 1'b1;
        if (st != c_ALU_BEGIN) begin
            expLat = 2 + busCyc;                      // agent cycles IDLE..DONE
            check("latency", 32'(cyc), 32'(expLat - 1 + (afterDone ? 2 : 0)));
        end
        check("bus_ops_outstanding", 32'(expOps.size()), 32'd0);
        check("alu_start_pulses", 32'(aluCnt), 32'(st == c_ALU_BEGIN));
        check("cond", cond, newOp[0]);
        check("src1", src1, newOp[1]);
        check("src0", src0, newOp[2]);
        mOp       = newOp;
        afterDone = 1'b1;
        start     = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        salt       = $urandom;
        rst        = 1'b1;
        start      = 1'b0;
        state      = c_WAIT_FOR_START;
        command    = '0;
        alu_result = '0;
        alu_done   = 1'b0;
        bus_ack    = 1'b0;
        bus_rdata  = '0;
        repeat (3) @(negedge clk);
        check("rst_bus_rd", 32'(bus_rd), 32'd0);
        check("rst_bus_wr", 32'(bus_wr), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_next_state", 32'(next_state), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_cond", cond, 32'd0);
        check("rst_src1", src1, 32'd0);
        check("rst_src0", src0, 32'd0);
        rst = 1'b0;
        mOp = '{32'd0, 32'd0, 32'd0};
        afterDone = 1'b0;
        @(negedge clk);
        runState(c_WAIT_FOR_START, 32'd0, 32'd0);

        // Register read with two wait states
        memOv[REG_BASE + 32'd3] = 32'h1234;
        forceWait = 2;
        runState(c_READ_SRC1, 32'h0000_0003, 32'd0);
        forceWait = -1;
        check("t2_src1", src1, 32'h0000_1234);
        check("t2_addr", lastRdAddr, 32'hFFFF_FF03);

        // Pointer read
        memOv[REG_BASE + 32'd3] = 32'h100;
        runState(c_READ_SRC1, 32'h0000_0003, 32'd0);
        memOv[32'h100] = 32'hBEEF;
        runState(c_READ_SRC1_P, 32'h0000_0003, 32'd0);
        check("t3_src1", src1, 32'h0000_BEEF);
        check("t3_addr", lastRdAddr, 32'h0000_0100);

        // Destination pointer write
        memOv[REG_BASE + 32'd2] = 32'h200;
        runState(c_WRITE_DST, 32'h0004_0200, 32'h55);
        check("t4_ptr_addr", lastRdAddr, 32'hFFFF_FF02);
        check("t4_wr_addr", lastWrAddr, 32'h0000_0200);
        check("t4_wr_data", lastWdata, 32'h0000_0055);

        // Post-decrement wrap
        memOv[REG_BASE + 32'd5] = 32'h0;
        runState(c_READ_SRC0, 32'h0000_0050, 32'd0);
        runState(c_WRITE_SRC0, 32'h0080_0050, 32'd0);
        check("t5_wr_addr", lastWrAddr, 32'hFFFF_FF05);
        check("t5_wr_data", lastWdata, 32'hFFFF_FFFF);
        check("t5_src0_kept", src0, 32'd0);

        // Post-increment wrap, then a flags==11 read that must not touch cond
        memOv[REG_BASE + 32'd7] = 32'hFFFF_FFFF;
        runState(c_READ_COND, 32'h0000_7000, 32'd0);
        runState(c_WRITE_COND, 32'h0400_7000, 32'd0);
        check("inc_wr_addr", lastWrAddr, 32'hFFFF_FF07);
        check("inc_wr_data", lastWdata, 32'd0);
        runState(c_READ_COND, 32'h0C00_8000, 32'd0);
        check("none_cond_kept", cond, 32'hFFFF_FFFF);

        // ALU with alu_done tied high, then quiet cycles: no extra strobes
        aluTied = 1'b1;
        runState(c_ALU_BEGIN, $urandom, 32'd0);
        state = c_WAIT_FOR_START;
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t6_no_extra_strobe", 32'(next_state), 32'd0);
            check("t6_no_extra_alu_start", 32'(alu_start), 32'd0);
        end
        aluTied   = 1'b0;
        afterDone = 1'b0;

        // Reset in the middle of an unacknowledged read
        state   = c_READ_SRC1;
        command = 32'h0000_0003;
        repeat (3) @(negedge clk);
        check("t1_req_up", 32'(bus_rd), 32'd1);
        rst   = 1'b1;
        state = c_WAIT_FOR_START;
        @(negedge clk);
        check("t1_bus_rd", 32'(bus_rd), 32'd0);
        check("t1_next_state", 32'(next_state), 32'd0);
        check("t1_bus_addr", bus_addr, 32'd0);
        check("t1_src1", src1, 32'd0);
        check("t1_cond", cond, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD;
        @(negedge clk);
        bus_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t1_late_ack_strobe", 32'(next_state), 32'd0);
            check("t1_late_ack_req", 32'(bus_rd | bus_wr), 32'd0);
            check("t1_late_ack_src1", src1, 32'd0);
        end
        mOp = '{32'd0, 32'd0, 32'd0};
        afterDone = 1'b0;

        // Randomized traffic
        repeat (150) begin
            runState(8'($urandom_range(0, 13)), $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
`default_nettype wire
